lighthouse_frame_tx: RTL

- Downstream stage of the pulse identification block. It consumes the identified polynomial and the eight per-sensor iteration offsets.
- On each result it latches the data, acknowledges the producer through that block's reset/ack input, then serializes a fixed 35-byte frame toward the UART transmitter.
- Frames carry a sequence number, a validity mask and an XOR checksum. A stalled UART is detected and the frame is aborted.

---
 rtl/lighthouse_frame_tx_if.sv | 34 +++
 rtl/lighthouse_frame_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/lighthouse_frame_tx_if.sv
// rtl/lighthouse_frame_tx_if.sv - producer handoff and UART byte stream bundle for lighthouse_frame_tx
interface lighthouse_frame_tx_if;
    logic        ident_ready;
    logic        ident_ack;
    logic [16:0] polynomial;
    logic [16:0] iteration_0;
    logic [16:0] iteration_1;
    logic [16:0] iteration_2;
    logic [16:0] iteration_3;
    logic [16:0] iteration_4;
    logic [16:0] iteration_5;
    logic [16:0] iteration_6;
    logic [16:0] iteration_7;
    logic [23:0] sys_ts;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  ident_ready, polynomial,
        input  iteration_0, iteration_1, iteration_2, iteration_3,
        input  iteration_4, iteration_5, iteration_6, iteration_7,
        input  sys_ts, tx_ready,
        output ident_ack, tx_data, tx_valid
    );

    modport slave (
        output ident_ready, polynomial,
        output iteration_0, iteration_1, iteration_2, iteration_3,
        output iteration_4, iteration_5, iteration_6, iteration_7,
        output sys_ts, tx_ready,
        input  ident_ack, tx_data, tx_valid
    );
endinterface

// File: rtl/lighthouse_frame_tx.sv
// rtl/lighthouse_frame_tx.sv - latches an identification result and serializes a 35-byte checksummed frame
module lighthouse_frame_tx #(
    parameter int         TX_TIMEOUT = 72000,
    parameter logic [7:0] HEADER0    = 8'hA5,
    parameter logic [7:0] HEADER1    = 8'h5A
) (
    input  logic                         clk_72MHz,
    input  logic                         reset,
    lighthouse_frame_tx_if.master        bus,
    output logic [15:0]                  frame_count,
    output logic [7:0]                   abort_count,
    output logic                         busy
);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CAPTURE, ACK, SEND, ABORT} state_t;
    state_t state, state_next;

    logic [16:0]   poly_cap;
    logic [16:0]   iter_cap [8];
    logic [16:0]   iter_in  [8];
    logic [23:0]   ts_cap;
    logic [7:0]    mask;
    logic [7:0]    seq;
    logic [7:0]    checksum;
    logic [5:0]    idx;
    logic [TW-1:0] timer;
    logic [7:0]    frame_byte [35];
    logic          xfer, stall, last_byte, timed_out;

    assign iter_in[0] = bus.iteration_0;
    assign iter_in[1] = bus.iteration_1;
    assign iter_in[2] = bus.iteration_2;
    assign iter_in[3] = bus.iteration_3;
    assign iter_in[4] = bus.iteration_4;
    assign iter_in[5] = bus.iteration_5;
    assign iter_in[6] = bus.iteration_6;
    assign iter_in[7] = bus.iteration_7;

    assign xfer      = (state == SEND) && bus.tx_ready;
    assign stall     = (state == SEND) && !bus.tx_ready;
    assign last_byte = (idx == 6'd34);
    assign timed_out = stall && (timer == TW'(TX_TIMEOUT - 1));

    // Frame image built from the captured snapshot; only byte 34 depends on transfer history.
    always_comb begin
        frame_byte[0] = HEADER0;
        frame_byte[1] = HEADER1;
        frame_byte[2] = seq;
        frame_byte[3] = {7'b0, poly_cap[16]};
        frame_byte[4] = poly_cap[15:8];
        frame_byte[5] = poly_cap[7:0];
        frame_byte[6] = mask;
        for (int i = 0; i < 8; i++) begin
            frame_byte[7 + 3*i] = {7'b0, iter_cap[i][16]};
            frame_byte[8 + 3*i] = iter_cap[i][15:8];
            frame_byte[9 + 3*i] = iter_cap[i][7:0];
        end
        frame_byte[31] = ts_cap[23:16];
        frame_byte[32] = ts_cap[15:8];
        frame_byte[33] = ts_cap[7:0];
        frame_byte[34] = checksum;
    end

    always_ff @(posedge clk_72MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.ident_ready) state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     if (!bus.ident_ready) state_next = SEND;
            SEND: begin
                if (xfer && last_byte) state_next = IDLE;
                else if (timed_out)    state_next = ABORT;
            end
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ident_ack = (state == ACK);
        bus.tx_valid  = (state == SEND);
        bus.tx_data   = (state == SEND) ? frame_byte[idx] : 8'h00;
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk_72MHz) begin
        if (reset) begin
            poly_cap    <= '0;
            ts_cap      <= '0;
            mask        <= '0;
            seq         <= '0;
            checksum    <= '0;
            idx         <= '0;
            timer       <= '0;
            frame_count <= '0;
            abort_count <= '0;
            for (int i = 0; i < 8; i++) iter_cap[i] <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    poly_cap <= bus.polynomial;
                    ts_cap   <= bus.sys_ts;
                    for (int i = 0; i < 8; i++) begin
                        iter_cap[i] <= iter_in[i];
                        mask[i]     <= (iter_in[i] != 17'd0);
                    end
                    checksum <= '0;
                    idx      <= '0;
                    timer    <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        idx   <= idx + 6'd1;
                        timer <= '0;
                        // Checksum accumulates as bytes 2..33 leave, so byte 34 is ready in time.
                        if (idx >= 6'd2 && idx <= 6'd33) checksum <= checksum ^ frame_byte[idx];
                        if (last_byte) begin
                            frame_count <= frame_count + 16'd1;
                            seq         <= seq + 8'd1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ABORT: begin
                    if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
